// File: rtl/pwm_level_decoder_if.sv
// Signal bundle between the LED-link GPIO input side and the level decoder.
// The master drives the stream and enable; the slave returns the decoded level and status.
interface pwm_level_decoder_if;
    logic       pwm_in;
    logic       enable;
    logic [3:0] level;
    logic       level_valid;
    logic       level_changed;
    logic       stuck_high;
    logic       window_done;

    modport master (
        output pwm_in,
        output enable,
        input  level,
        input  level_valid,
        input  level_changed,
        input  stuck_high,
        input  window_done
    );

    modport slave (
        input  pwm_in,
        input  enable,
        output level,
        output level_valid,
        output level_changed,
        output stuck_high,
        output window_done
    );
endinterface

// File: rtl/pwm_level_decoder.sv
// Recovers the 4-bit LED level from a pulse-density stream.
// High cycles are counted over free-running windows, and a level is published only once it repeats across windows.
module pwm_level_decoder #(
    parameter int WIN_SHIFT  = 0,
    parameter int STABLE_CNT = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    pwm_level_decoder_if.slave bus
);
    localparam int WIN_LEN = 16 << WIN_SHIFT;
    localparam int CNT_W   = WIN_SHIFT + 4;
    localparam int HC_W    = WIN_SHIFT + 5;

    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_LEN - 1);
    localparam logic [HC_W-1:0]  WIN_FULL   = HC_W'(WIN_LEN);
    localparam logic [HC_W-1:0]  RAW_MAX    = HC_W'(15);
    localparam logic [2:0]       STABLE_MIN = 3'(STABLE_CNT);

    logic             sync_meta_q, sync_meta_d;
    logic             pwm_s_q, pwm_s_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [HC_W-1:0]  high_cnt_q, high_cnt_d;
    logic [3:0]       raw_prev_q, raw_prev_d;
    logic [2:0]       run_q, run_d;
    logic [3:0]       level_q, level_d;
    logic             level_valid_q, level_valid_d;
    logic             level_changed_q, level_changed_d;
    logic             stuck_high_q, stuck_high_d;
    logic             window_done_q, window_done_d;

    logic [HC_W-1:0]  total;
    logic [HC_W-1:0]  scaled;
    logic [3:0]       raw;
    logic [2:0]       run_new;

    // Window-end quantities are computed every cycle; only the last cycle of a window uses them.
    always_comb begin
        total   = high_cnt_q + HC_W'(pwm_s_q);
        scaled  = total >> WIN_SHIFT;
        raw     = (scaled > RAW_MAX) ? 4'hF : scaled[3:0];
        run_new = 3'd1;
        if ((raw == raw_prev_q) && (run_q != 3'd0)) begin
            run_new = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;
        end
    end

    always_comb begin
        sync_meta_d     = bus.pwm_in;
        pwm_s_d         = sync_meta_q;
        win_cnt_d       = win_cnt_q;
        high_cnt_d      = high_cnt_q;
        raw_prev_d      = raw_prev_q;
        run_d           = run_q;
        level_d         = level_q;
        level_valid_d   = level_valid_q;
        level_changed_d = 1'b0;
        stuck_high_d    = stuck_high_q;
        window_done_d   = 1'b0;

        if (!bus.enable) begin
            // Clearing run means a re-enabled measurement must earn stability from scratch.
            win_cnt_d  = '0;
            high_cnt_d = '0;
            run_d      = 3'd0;
        end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d     = '0;
            high_cnt_d    = '0;
            stuck_high_d  = (total == WIN_FULL);
            window_done_d = 1'b1;
            raw_prev_d    = raw;
            run_d         = run_new;
            if (run_new >= STABLE_MIN) begin
                level_d         = raw;
                level_valid_d   = 1'b1;
                level_changed_d = !level_valid_q || (raw != level_q);
            end
        end else begin
            win_cnt_d  = win_cnt_q + CNT_W'(1);
            high_cnt_d = total;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_meta_q     <= 1'b0;
            pwm_s_q         <= 1'b0;
            win_cnt_q       <= '0;
            high_cnt_q      <= '0;
            raw_prev_q      <= 4'd0;
            run_q           <= 3'd0;
            level_q         <= 4'd0;
            level_valid_q   <= 1'b0;
            level_changed_q <= 1'b0;
            stuck_high_q    <= 1'b0;
            window_done_q   <= 1'b0;
        end else begin
            sync_meta_q     <= sync_meta_d;
            pwm_s_q         <= pwm_s_d;
            win_cnt_q       <= win_cnt_d;
            high_cnt_q      <= high_cnt_d;
            raw_prev_q      <= raw_prev_d;
            run_q           <= run_d;
            level_q         <= level_d;
            level_valid_q   <= level_valid_d;
            level_changed_q <= level_changed_d;
            stuck_high_q    <= stuck_high_d;
            window_done_q   <= window_done_d;
        end
    end

    assign bus.level         = level_q;
    assign bus.level_valid   = level_valid_q;
    assign bus.level_changed = level_changed_q;
    assign bus.stuck_high    = stuck_high_q;
    assign bus.window_done   = window_done_q;
endmodule

// File: tb/tb_pwm_level_decoder.sv
// Bench for pwm_level_decoder: a 16-cycle-window instance and a 64-cycle-window instance fed by accumulator stream generators.
// Expected per-window outputs are queued as each window is driven and popped on window_done.
module tb_pwm_level_decoder;
    logic clk = 1'b0;
    logic rst_n;
    logic pwm0 = 1'b0, pwm1 = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [6:0] q0[$];
    logic [6:0] q1[$];
    logic [6:0] e0, e1, exp_v;

    logic [4:0] acc0 = 5'd0, acc1 = 5'd0;
    int k0 = 0, k1 = 0;
    bit hi0 = 1'b0, hi1 = 1'b0;

    int pulses0 = 0, pulses1 = 0, done0 = 0, done1 = 0;
    int snap_p, snap_d;
    bit in_idle = 1'b0, idle_nonzero = 1'b0;
    bit in_sweep = 1'b0, stuck_seen0 = 1'b0;
    bit in_step = 1'b0, step_glitch = 1'b0;

    pwm_level_decoder_if bus0 ();
    pwm_level_decoder_if bus1 ();

    assign bus0.pwm_in = pwm0;
    assign bus0.enable = en0;
    assign bus1.pwm_in = pwm1;
    assign bus1.enable = en1;

    pwm_level_decoder #(.WIN_SHIFT(0), .STABLE_CNT(2)) u0 (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus0)
    );

    pwm_level_decoder #(.WIN_SHIFT(2), .STABLE_CNT(2)) u1 (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus1)
    );

    always #10 clk = ~clk;

    function automatic logic [6:0] pk(input int lvl, input bit v, input bit c, input bit s);
        return {4'(lvl), v, c, s};
    endfunction

    function automatic logic [7:0] outs0();
        return {bus0.level, bus0.level_valid, bus0.level_changed, bus0.stuck_high, bus0.window_done};
    endfunction

    function automatic logic [7:0] outs1();
        return {bus1.level, bus1.level_valid, bus1.level_changed, bus1.stuck_high, bus1.window_done};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One stream cycle: optionally change enable, emit the next accumulator carry, wait for the edge.
    task automatic tick(input int sel, input int en_cmd);
        @(negedge clk);
        if (sel == 0) begin
            if (en_cmd >= 0) en0 = (en_cmd == 1);
            if (hi0) pwm0 = 1'b1;
            else begin
                acc0 = {1'b0, acc0[3:0]} + 5'(k0);
                pwm0 = acc0[4];
            end
        end else begin
            if (en_cmd >= 0) en1 = (en_cmd == 1);
            if (hi1) pwm1 = 1'b1;
            else begin
                acc1 = {1'b0, acc1[3:0]} + 5'(k1);
                pwm1 = acc1[4];
            end
        end
        @(posedge clk);
    endtask

    // Drives exactly the stream samples one decoder window will count, after queueing its expected result.
    task automatic apply_stimulus(input int sel, input int en_at, input int k_a, input int k_b,
                                  input int change_at, input bit hi, input logic [6:0] exp);
        int w;
        w = (sel == 0) ? 16 : 64;
        if (sel == 0) begin
            q0.push_back(exp);
            k0  = k_a;
            hi0 = hi;
        end else begin
            q1.push_back(exp);
            k1  = k_a;
            hi1 = hi;
        end
        for (int i = 0; i < w; i++) begin
            if (i == change_at) begin
                if (sel == 0) k0 = k_b;
                else k1 = k_b;
            end
            tick(sel, (i == en_at) ? 1 : -1);
        end
    endtask

    task automatic win0(input int k, input logic [6:0] exp);
        apply_stimulus(0, -1, k, k, -1, 1'b0, exp);
    endtask

    always @(negedge clk) begin
        if (bus0.window_done === 1'b1) begin
            done0++;
            check_output("d0_done_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                check_output("d0_window", {bus0.level, bus0.level_valid, bus0.level_changed, bus0.stuck_high}, e0);
            end
        end
        if (bus0.level_changed === 1'b1) begin
            pulses0++;
            check_output("d0_pulse_with_done", bus0.window_done, 1);
        end
        if (bus1.window_done === 1'b1) begin
            done1++;
            check_output("d1_done_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check_output("d1_window", {bus1.level, bus1.level_valid, bus1.level_changed, bus1.stuck_high}, e1);
            end
        end
        if (bus1.level_changed === 1'b1) begin
            pulses1++;
            check_output("d1_pulse_with_done", bus1.window_done, 1);
        end
        if (in_idle && (outs0() != 8'd0 || outs1() != 8'd0)) idle_nonzero = 1'b1;
        if (in_sweep && bus0.stuck_high) stuck_seen0 = 1'b1;
        if (in_step && bus0.level >= 4'd5 && bus0.level <= 4'd10) step_glitch = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Async reset with no clock edge in between.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        check_output("rst_async_d0", outs0(), 0);
        check_output("rst_async_d1", outs1(), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pwm0 = ~pwm0;
            pwm1 = ~pwm1;
        end
        check_output("rst_hold_d0", outs0(), 0);
        check_output("rst_hold_d1", outs1(), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        in_idle = 1'b1;
        repeat (100) @(posedge clk);
        in_idle = 1'b0;
        check_output("idle_outputs", idle_nonzero, 0);
        check_output("idle_done_d0", done0, 0);
        check_output("idle_done_d1", done1, 0);

        // Basic acquisition at k=9.
        snap_p = pulses0;
        apply_stimulus(0, 2, 9, 9, -1, 1'b0, pk(0, 0, 0, 0));
        win0(9, pk(9, 1, 1, 0));
        for (int w = 0; w < 20; w++) win0(9, pk(9, 1, 0, 0));
        repeat (8) tick(0, -1);
        check_output("acq_pulses", pulses0 - snap_p, 1);
        check_output("acq_queue_empty", q0.size(), 0);

        // Async reset mid-window, between edges.
        #3 rst_n = 1'b0;
        #1 check_output("rst_mid_d0", outs0(), 0);
        en0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep k=0..15, five windows each.
        snap_p   = pulses0;
        in_sweep = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int w = 0; w < 5; w++) begin
                if (w == 0) exp_v = (k == 0) ? pk(0, 0, 0, 0) : pk(k - 1, 1, 0, 0);
                else if (w == 1) exp_v = pk(k, 1, 1, 0);
                else exp_v = pk(k, 1, 0, 0);
                apply_stimulus(0, (k == 0 && w == 0) ? 2 : -1, k, k, -1, 1'b0, exp_v);
            end
        end
        check_output("sweep_pulses", pulses0 - snap_p, 16);

        // Step 4 -> 11 with one straddling window.
        win0(4, pk(15, 1, 0, 0));
        in_sweep = 1'b0;
        check_output("sweep_no_stuck", stuck_seen0, 0);
        win0(4, pk(4, 1, 1, 0));
        win0(4, pk(4, 1, 0, 0));
        snap_p  = pulses0;
        in_step = 1'b1;
        apply_stimulus(0, -1, 4, 11, 8, 1'b0, pk(4, 1, 0, 0));
        win0(11, pk(4, 1, 0, 0));
        win0(11, pk(11, 1, 1, 0));
        win0(11, pk(11, 1, 0, 0));
        in_step = 1'b0;
        check_output("step_pulses", pulses0 - snap_p, 1);
        check_output("step_no_glitch", step_glitch, 0);

        // Enable dropped mid-window at k=3.
        win0(3, pk(11, 1, 0, 0));
        win0(3, pk(3, 1, 1, 0));
        win0(3, pk(3, 1, 0, 0));
        repeat (8) tick(0, -1);
        snap_d = done0;
        snap_p = pulses0;
        tick(0, 0);
        repeat (9) tick(0, -1);
        check_output("en_low_no_done", done0 - snap_d, 0);
        check_output("en_low_level", bus0.level, 3);
        check_output("en_low_valid", bus0.level_valid, 1);
        apply_stimulus(0, 0, 3, 3, -1, 1'b0, pk(3, 1, 0, 0));
        win0(3, pk(3, 1, 0, 0));
        @(negedge clk);
        en0 = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reen_pulses", pulses0 - snap_p, 0);
        check_output("d0_queue_drained", q0.size(), 0);

        // W=64 instance: constant-high stream, then k=6.
        apply_stimulus(1, 2, 0, 0, -1, 1'b1, pk(0, 0, 0, 1));
        apply_stimulus(1, -1, 0, 0, -1, 1'b1, pk(15, 1, 1, 1));
        apply_stimulus(1, -1, 6, 6, -1, 1'b0, pk(15, 1, 0, 0));
        apply_stimulus(1, -1, 6, 6, -1, 1'b0, pk(6, 1, 1, 0));
        apply_stimulus(1, -1, 6, 6, -1, 1'b0, pk(6, 1, 0, 0));
        repeat (2) tick(1, -1);
        @(negedge clk);
        en1 = 1'b0;
        repeat (3) @(negedge clk);
        check_output("d1_pulses", pulses1, 2);
        check_output("d1_queue_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_level_decoder.md
Name: pwm_level_decoder

Overview:
- Receiving end of the board's LED intensity link.
- The LED driver emits a 1-bit pulse-density stream from a 5-bit accumulator: each cycle it adds a 4-bit level k to its low 4 bits and outputs the carry. Any 16 consecutive cycles therefore contain exactly k high cycles.
- This block samples such a stream on a GPIO input, counts high cycles over fixed windows, and recovers k.
- After debouncing across windows, it presents k as a 4-bit level for the seven-segment display path and for loopback checking.

Parameters:
WIN_SHIFT, 0, window length W = 16 << WIN_SHIFT cycles; raw level = high count >> WIN_SHIFT
STABLE_CNT, 2, consecutive equal-raw windows (1..7) required before level updates

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous active-low reset
pwm_in  input  1  pulse-density stream from GPIO, asynchronous to CLOCK_50
enable  input  1  1 = measure; 0 = restart window, hold outputs
level  output  4  decoded intensity 0..15
level_valid  output  1  level holds a debounced value
level_changed  output  1  one-cycle pulse when level/level_valid is updated to a new value
stuck_high  output  1  last window was all-ones (not producible by a legal stream)
window_done  output  1  one-cycle pulse after each completed window

Behaviour:
- Reset (reset==0, asynchronous, no clock needed): all of the following clear to 0 immediately: sync flops, win_cnt, high_cnt, raw_prev, run, level, level_valid, level_changed, stuck_high, window_done.
- Input conditioning:
  - 2-flop synchronizer on pwm_in; pwm_s is the second flop output.
  - Sync latency is 2 cycles. It does not change counts, because windows are free-running.
- Window counting (enable==1):
  - win_cnt counts 0..W-1 and wraps.
  - high_cnt adds pwm_s each cycle. high_cnt is WIN_SHIFT+5 bits wide and must hold W without overflow.
- Window end (the edge on which win_cnt==W-1):
  - total = high_cnt + pwm_s.
  - raw = min(total >> WIN_SHIFT, 15).
  - stuck_high <= (total == W).
  - window_done <= 1 for exactly the next cycle.
  - win_cnt <= 0 and high_cnt <= 0.
- Stability, evaluated on the same edge:
  - run_new = (raw == raw_prev && run != 0) ? min(run+1, 7) : 1.
  - raw_prev <= raw; run <= run_new.
  - If run_new >= STABLE_CNT:
    - level <= raw; level_valid <= 1.
    - level_changed <= 1 iff (level_valid==0 || raw != level).
  - Otherwise level and level_valid hold.
- level_changed and window_done are 0 in every cycle other than the one following a qualifying window end.
- Output timing: outputs are registered, so updates are visible 1 cycle after the window-end edge, together with window_done.
- enable==0:
  - Each cycle: win_cnt <= 0, high_cnt <= 0, run <= 0.
  - level, level_valid and stuck_high hold.
  - No pulses.
  - Re-enabling starts a full new window. The first window after re-enable can only count as run=1.
- Level changes on the stream:
  - The window straddling the change yields a mixed raw value.
  - A mixed value alone never reaches STABLE_CNT>=2, so no intermediate level is ever published.
  - Worst-case update latency is (STABLE_CNT+1)*W + 3 cycles after the stream changes.
- Constant-low stream decodes to level 0, a legal value.
- Constant-high stream: stuck_high=1, raw saturates to 15, and level becomes 15 after STABLE_CNT windows.
- Reset asserted mid-window discards the partial window. After release, re-acquisition needs STABLE_CNT full windows.

Test Plan:
- Reset check: hold reset=0 while pwm_in toggles; release with enable=0 for 100 cycles -> all outputs stay 0 and no window_done.
- Basic acquire (defaults): enable=1, drive from a behavioural 5-bit accumulator model with k=9 -> window_done every 16 cycles; level=9, level_valid=1 and a single level_changed pulse appear by the end of the second full window; no further pulses over 20 windows.
- Sweep: k=0..15, each held 80 cycles -> level follows every k; exactly 16 level_changed pulses, including invalid->0; stuck_high stays 0 throughout.
- Step without glitch: k=4 held to steady state, then k=11 -> level stays 4 until it jumps directly to 11 within 3 windows + 3 cycles; it never shows 5..10; exactly one pulse.
- Stuck and WIN_SHIFT: WIN_SHIFT=2 (W=64), pwm_in=1 constant -> stuck_high=1 after the first window end; level=15 after 2 windows. Then k=6 -> stuck_high=0 at the next window end, and level=6 follows.
- Async reset / enable: pull reset low mid-window between clock edges -> outputs 0 before the next edge. Drop enable for 10 cycles mid-window at k=3 -> no window_done during the low period; level holds 3; re-acquired with no pulse, since the value is unchanged.
